// File: rtl/router_pkg.sv
// Shared types for the router output arbiter: flit type encoding, type-field
// position and arbiter FSM states.
package router_pkg;

    typedef enum logic [1:0] {
        FLIT_BODY   = 2'b00,
        FLIT_HEAD   = 2'b01,
        FLIT_TAIL   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_type_t;

    // Type-field bit positions, counted downward from the flit MSB.
    localparam int FlitTypeMsb = 0;
    localparam int FlitTypeLsb = 1;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // HEAD and SINGLE both open a packet.
    function automatic logic is_head_like(flit_type_t t);
        return (t == FLIT_HEAD) || (t == FLIT_SINGLE);
    endfunction

endpackage

// File: rtl/router_output_arbiter_if.sv
// Bundle of the input-FIFO, output-FIFO and status signals of one output port.
// master is the arbiter side, slave is the surrounding router/environment.
interface router_output_arbiter_if #(
    parameter int NumInputs  = 4,
    parameter int Width      = 10,
    parameter int CountWidth = 16
) ();

    logic [NumInputs-1:0]            in_empty;
    logic [NumInputs-1:0][Width-1:0] in_data;
    logic [NumInputs-1:0]            in_rdreq;
    logic                            out_full;
    logic                            out_wrreq;
    logic [Width-1:0]                out_data;
    logic [NumInputs-1:0]            grant;
    logic                            locked;
    logic                            proto_err;
    logic [CountWidth-1:0]           pkt_count;

    modport master (
        input  in_empty, in_data, out_full,
        output in_rdreq, out_wrreq, out_data, grant, locked, proto_err, pkt_count
    );

    modport slave (
        output in_empty, in_data, out_full,
        input  in_rdreq, out_wrreq, out_data, grant, locked, proto_err, pkt_count
    );

endinterface

// File: rtl/router_output_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after i_ptr,
// scanning upward with wrap-around; one-hot grant plus its index.
module rr_arbiter #(
    parameter  int NumInputs = 4,
    localparam int PtrW      = $clog2(NumInputs)
) (
    input  logic [NumInputs-1:0] i_req,
    input  logic [PtrW-1:0]      i_ptr,
    output logic [NumInputs-1:0] o_grant,
    output logic [PtrW-1:0]      o_idx,
    output logic                 o_valid
);

    logic [PtrW:0]   w_sum;
    logic [PtrW-1:0] w_cand;

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_sum   = '0;
        w_cand  = '0;
        for (int i = 0; i < NumInputs; i++) begin
            w_sum = {1'b0, i_ptr} + (PtrW+1)'(i);
            if (w_sum >= (PtrW+1)'(NumInputs)) begin
                w_sum = w_sum - (PtrW+1)'(NumInputs);
            end
            w_cand = w_sum[PtrW-1:0];
            if (!o_valid && i_req[w_cand]) begin
                o_valid         = 1'b1;
                o_idx           = w_cand;
                o_grant[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/router_output_arbiter.sv
// Wormhole output-port arbiter: round-robin among packets, grant held from
// head to tail, zero-latency combinational data path to the output FIFO.
module router_output_arbiter
    import router_pkg::*;
#(
    parameter int NumInputs  = 4,
    parameter int Width      = 10,
    parameter int CountWidth = 16
) (
    input logic                   clk,
    input logic                   rst,
    router_output_arbiter_if.master bus
);

    localparam int PtrW   = $clog2(NumInputs);
    localparam int TypeHi = Width - 1 - FlitTypeMsb;
    localparam int TypeLo = Width - 1 - FlitTypeLsb;

    arb_state_t            r_state;
    arb_state_t            w_state_nxt;
    logic [PtrW-1:0]       r_owner;
    logic [PtrW-1:0]       r_prio_ptr;
    logic                  r_proto_err;
    logic [CountWidth-1:0] r_pkt_count;

    logic [NumInputs-1:0]  w_eligible;
    logic [NumInputs-1:0]  w_bad_idle;
    logic [NumInputs-1:0]  w_rr_grant;
    logic [PtrW-1:0]       w_rr_idx;
    logic                  w_rr_valid;
    logic [NumInputs-1:0]  w_grant;
    logic [PtrW-1:0]       w_owner;
    logic [PtrW-1:0]       w_next_ptr;
    logic [Width-1:0]      w_owner_flit;
    flit_type_t            w_owner_type;
    flit_type_t            w_in_type;
    logic                  w_type_ok;
    logic                  w_xfer;
    logic                  w_pkt_done;
    logic                  w_err_set;

    always_comb begin
        w_eligible = '0;
        w_bad_idle = '0;
        w_in_type  = FLIT_BODY;
        for (int i = 0; i < NumInputs; i++) begin
            w_in_type     = flit_type_t'(bus.in_data[i][TypeHi:TypeLo]);
            w_eligible[i] = !bus.in_empty[i] && is_head_like(w_in_type);
            w_bad_idle[i] = !bus.in_empty[i] && !is_head_like(w_in_type);
        end
    end

    rr_arbiter #(
        .NumInputs (NumInputs)
    ) u_rr (
        .i_req   (w_eligible),
        .i_ptr   (r_prio_ptr),
        .o_grant (w_rr_grant),
        .o_idx   (w_rr_idx),
        .o_valid (w_rr_valid)
    );

    // Grant is forced to zero while in reset so nothing is popped or pushed.
    always_comb begin
        w_owner      = (r_state == ARB_LOCKED) ? r_owner : w_rr_idx;
        w_owner_flit = bus.in_data[w_owner];
        w_owner_type = flit_type_t'(w_owner_flit[TypeHi:TypeLo]);
        w_grant      = '0;
        if (rst) begin
            if (r_state == ARB_LOCKED) begin
                w_grant = NumInputs'(1) << r_owner;
            end else if (w_rr_valid) begin
                w_grant = w_rr_grant;
            end
        end
        w_type_ok  = (r_state == ARB_LOCKED) ? !is_head_like(w_owner_type)
                                             : is_head_like(w_owner_type);
        w_xfer     = (|w_grant) && !bus.in_empty[w_owner] && !bus.out_full && w_type_ok;
        w_next_ptr = (w_owner == PtrW'(NumInputs - 1)) ? '0 : w_owner + PtrW'(1);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pkt_done  = 1'b0;
        w_err_set   = 1'b0;
        unique case (r_state)
            ARB_IDLE: begin
                w_err_set = |w_bad_idle;
                if (w_xfer && (w_owner_type == FLIT_HEAD)) begin
                    w_state_nxt = ARB_LOCKED;
                end
                if (w_xfer && (w_owner_type == FLIT_SINGLE)) begin
                    w_pkt_done = 1'b1;
                end
            end
            ARB_LOCKED: begin
                w_err_set = !bus.in_empty[r_owner] && is_head_like(w_owner_type);
                if (w_xfer && (w_owner_type == FLIT_TAIL)) begin
                    w_state_nxt = ARB_IDLE;
                    w_pkt_done  = 1'b1;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ARB_IDLE;
            r_owner     <= '0;
            r_prio_ptr  <= '0;
            r_proto_err <= 1'b0;
            r_pkt_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ARB_IDLE) && w_xfer) begin
                r_owner <= w_owner;
            end
            if (w_pkt_done) begin
                r_prio_ptr <= w_next_ptr;
            end
            if (w_err_set) begin
                r_proto_err <= 1'b1;
            end
            if (w_pkt_done && !(&r_pkt_count)) begin
                r_pkt_count <= r_pkt_count + CountWidth'(1);
            end
        end
    end

    assign bus.in_rdreq  = w_xfer ? w_grant : '0;
    assign bus.out_wrreq = w_xfer;
    assign bus.out_data  = w_owner_flit;
    assign bus.grant     = w_grant;
    assign bus.locked    = (r_state == ARB_LOCKED);
    assign bus.proto_err = r_proto_err;
    assign bus.pkt_count = r_pkt_count;

    a_rdreq_onehot0 : assert property (@(posedge clk) disable iff (!rst)
        $onehot0(bus.in_rdreq));
    a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst)
        $onehot0(bus.grant));
    a_no_push_full : assert property (@(posedge clk)
        bus.out_wrreq |-> !bus.out_full);
    a_lock_stable : assert property (@(posedge clk) disable iff (!rst)
        (rst && !w_xfer) |=> $stable(bus.locked));
    a_owner_only : assert property (@(posedge clk) disable iff (!rst)
        bus.locked |-> ((bus.in_rdreq & ~(NumInputs'(1) << r_owner)) == '0));

endmodule

// File: tb/tb_router_output_arbiter.sv
// Directed bench for router_output_arbiter: queue-backed input FIFOs, a
// scoreboard of expected output flits and direct checks of the status outputs.
module tb_router_output_arbiter;
    import router_pkg::*;

    localparam int NI = 4;
    localparam int W  = 10;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    router_output_arbiter_if #(.NumInputs(NI), .Width(W), .CountWidth(CW)) bus ();

    router_output_arbiter #(.NumInputs(NI), .Width(W), .CountWidth(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [W-1:0] flit;
        int           src;
    } exp_t;

    int           n_checks = 0;
    int           n_fail   = 0;
    exp_t         exp_q[$];
    logic [W-1:0] src_q[NI][$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [W-1:0] mk(input flit_type_t t, input logic [7:0] p);
        return {t, p};
    endfunction

    task automatic send(input int src, input flit_type_t t, input logic [7:0] p, input bit expect_out);
        exp_t e;
        src_q[src].push_back(mk(t, p));
        if (expect_out) begin
            e.flit = mk(t, p);
            e.src  = src;
            exp_q.push_back(e);
        end
    endtask

    // Input FIFOs: pop on rdreq at the edge, present new heads at posedge+3.
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (bus.in_rdreq[i] && (src_q[i].size() > 0)) begin
                void'(src_q[i].pop_front());
            end
        end
        #3;
        for (int i = 0; i < NI; i++) begin
            bus.in_empty[i] = (src_q[i].size() == 0);
            bus.in_data[i]  = (src_q[i].size() > 0) ? src_q[i][0] : '0;
        end
    end

    // Scoreboard: every downstream push must match the next expected flit.
    always @(negedge clk) begin
        exp_t e;
        if (bus.out_wrreq) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_push: got 0x%0h, expected no push at %0t", bus.out_data, $time);
            end else begin
                e = exp_q.pop_front();
                check("out_data", 32'(bus.out_data), 32'(e.flit));
                check("out_src", 32'(bus.grant), 32'(1 << e.src));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int    t;
        int    wh_grant[6];
        bit    wh_lock[6];
        wh_grant = '{2, 2, 2, 2, 4, 4};
        wh_lock  = '{0, 1, 1, 1, 0, 1};
        bus.out_full = 1'b0;

        // Reset with every input holding a SINGLE flit.
        for (int i = 0; i < NI; i++) send(i, FLIT_SINGLE, 8'h10 + 8'(i), 1'b1);
        tick(); neg();
        check("rst_rdreq", 32'(bus.in_rdreq), 0);
        check("rst_wrreq", 32'(bus.out_wrreq), 0);
        check("rst_pkt_count", 32'(bus.pkt_count), 0);
        check("rst_proto_err", 32'(bus.proto_err), 0);
        check("rst_locked", 32'(bus.locked), 0);
        tick(); neg();
        check("rst_rdreq2", 32'(bus.in_rdreq), 0);
        check("rst_wrreq2", 32'(bus.out_wrreq), 0);

        // Release: round robin 0,1,2,3 on consecutive cycles.
        tick(); rst = 1'b1;
        for (int k = 0; k < NI; k++) begin
            if (k > 0) tick();
            neg();
            check("rr_grant", 32'(bus.grant), 32'(1 << k));
            check("rr_wrreq", 32'(bus.out_wrreq), 1);
            check("rr_locked", 32'(bus.locked), 0);
        end
        tick(); neg();
        check("rr_pkt_count", 32'(bus.pkt_count), 4);
        check("rr_idle_wrreq", 32'(bus.out_wrreq), 0);

        // Wormhole: input 1 packet runs uninterrupted, input 2 waits at its HEAD.
        tick();
        send(1, FLIT_HEAD, 8'hA0, 1'b1);
        send(1, FLIT_BODY, 8'hA1, 1'b1);
        send(1, FLIT_BODY, 8'hA2, 1'b1);
        send(1, FLIT_TAIL, 8'hA3, 1'b1);
        send(2, FLIT_HEAD, 8'hB0, 1'b1);
        send(2, FLIT_TAIL, 8'hB1, 1'b1);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) tick();
            neg();
            check("wh_wrreq", 32'(bus.out_wrreq), 1);
            check("wh_grant", 32'(bus.grant), 32'(wh_grant[k]));
            check("wh_locked", 32'(bus.locked), 32'(wh_lock[k]));
        end
        tick(); neg();
        check("wh_pkt_count", 32'(bus.pkt_count), 6);
        check("wh_unlocked", 32'(bus.locked), 0);

        // Backpressure mid-packet on input 0.
        tick();
        send(0, FLIT_HEAD, 8'hC0, 1'b1);
        send(0, FLIT_BODY, 8'hC1, 1'b1);
        send(0, FLIT_BODY, 8'hC2, 1'b1);
        send(0, FLIT_TAIL, 8'hC3, 1'b1);
        neg();
        check("bp_grant", 32'(bus.grant), 1);
        check("bp_wrreq_head", 32'(bus.out_wrreq), 1);
        tick(); neg();
        check("bp_wrreq_body", 32'(bus.out_wrreq), 1);
        check("bp_locked", 32'(bus.locked), 1);
        for (int k = 0; k < 3; k++) begin
            tick(); bus.out_full = 1'b1;
            neg();
            check("bp_full_wrreq", 32'(bus.out_wrreq), 0);
            check("bp_full_rdreq", 32'(bus.in_rdreq), 0);
            check("bp_full_grant", 32'(bus.grant), 1);
            check("bp_full_locked", 32'(bus.locked), 1);
        end
        tick(); bus.out_full = 1'b0;
        neg();
        check("bp_resume", 32'(bus.out_wrreq), 1);
        tick(); neg();
        check("bp_tail", 32'(bus.out_wrreq), 1);
        tick(); neg();
        check("bp_done_locked", 32'(bus.locked), 0);
        check("bp_pkt_count", 32'(bus.pkt_count), 7);

        // Protocol error: BODY at the head of input 3 while idle.
        tick();
        send(3, FLIT_BODY, 8'hD0, 1'b0);
        neg();
        check("pe_grant", 32'(bus.grant), 0);
        check("pe_err_before", 32'(bus.proto_err), 0);
        tick(); neg();
        check("pe_err_set", 32'(bus.proto_err), 1);
        tick();
        send(0, FLIT_SINGLE, 8'hE0, 1'b1);
        neg();
        check("pe_other_grant", 32'(bus.grant), 1);
        tick(); neg();
        check("pe_sticky", 32'(bus.proto_err), 1);
        check("pe_rdreq3", 32'(bus.in_rdreq[3]), 0);
        tick();
        src_q[3].delete();
        rst = 1'b0;
        tick(); rst = 1'b1;
        neg();
        check("pe_reset_clear", 32'(bus.proto_err), 0);
        check("pe_reset_count", 32'(bus.pkt_count), 0);

        // Counter saturation: 20 SINGLE flits, 4-bit counter stops at 15.
        tick();
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < NI; i++) send(i, FLIT_SINGLE, 8'(r * 16 + i), 1'b1);
        end
        repeat (24) tick();
        neg();
        check("sat_pkt_count", 32'(bus.pkt_count), 15);

        t = 0;
        while ((exp_q.size() != 0) && (t < 100)) begin
            tick();
            t++;
        end
        check("drain_outstanding", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
